// File: rtl/ahb3lite_dma_master_arb.sv
// Two-to-one AHB3-Lite master arbiter: shares one downstream master port between two
// requesters, tracking address- and data-phase ownership separately.
module ahb3lite_dma_master_arb #(
    parameter bit PRI_FIXED     = 1'b0,
    parameter bit DEFAULT_OWNER = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic        m0HSEL,
    input  logic        m0HWRITE,
    input  logic [31:0] m0HADDR,
    input  logic [31:0] m0HWDATA,
    input  logic [2:0]  m0HSIZE,
    input  logic [2:0]  m0HBURST,
    input  logic [3:0]  m0HPROT,
    input  logic [1:0]  m0HTRANS,
    input  logic        m0HREADY,
    output logic [31:0] m0HRDATA,
    output logic        m0HREADYOUT,
    output logic        m0HRESP,

    input  logic        m1HSEL,
    input  logic        m1HWRITE,
    input  logic [31:0] m1HADDR,
    input  logic [31:0] m1HWDATA,
    input  logic [2:0]  m1HSIZE,
    input  logic [2:0]  m1HBURST,
    input  logic [3:0]  m1HPROT,
    input  logic [1:0]  m1HTRANS,
    input  logic        m1HREADY,
    output logic [31:0] m1HRDATA,
    output logic        m1HREADYOUT,
    output logic        m1HRESP,

    output logic        dHSEL,
    output logic        dHWRITE,
    output logic [31:0] dHADDR,
    output logic [31:0] dHWDATA,
    output logic [2:0]  dHSIZE,
    output logic [2:0]  dHBURST,
    output logic [3:0]  dHPROT,
    output logic [1:0]  dHTRANS,
    output logic        dHREADY,
    input  logic [31:0] dHRDATA,
    input  logic        dHREADYOUT,
    input  logic        dHRESP,

    output logic        owner_o
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    logic owner_q,  owner_d;
    logic dvalid_q, dvalid_d;
    logic downer_q, downer_d;

    logic       req0, req1;
    logic       own_sel, own_req, lock;
    logic [1:0] own_trans;
    logic       gnt;
    logic       g_sel;
    logic [1:0] g_trans;

    // Requesters' HREADY is meaningless here: they only ever see our HREADYOUT.
    logic unused_ok;
    assign unused_ok = &{1'b0, m0HREADY, m1HREADY};

    assign req0 = m0HSEL & m0HTRANS[1];
    assign req1 = m1HSEL & m1HTRANS[1];

    // NOTE: state flops use non-blocking assignments and reset asynchronously;
    // combinational blocks use blocking assignments.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_q  <= DEFAULT_OWNER;
            dvalid_q <= 1'b0;
            downer_q <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            dvalid_q <= dvalid_d;
            downer_q <= downer_d;
        end
    end

    // Grant and next state. A burst (SEQ/BUSY) or a back-to-back request behind the
    // owner's own data phase locks the grant so bursts are never split.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        own_sel   = owner_q ? m1HSEL   : m0HSEL;
        own_trans = owner_q ? m1HTRANS : m0HTRANS;
        own_req   = owner_q ? req1     : req0;
        lock      = (own_sel && (own_trans == HTRANS_SEQ || own_trans == HTRANS_BUSY))
                  || (own_req && dvalid_q && (downer_q == owner_q));

        gnt = owner_q;
        if (!dHREADYOUT || lock) begin
            gnt = owner_q;
        end else if (req0 && req1) begin
            gnt = PRI_FIXED ? 1'b0 : !owner_q;
        end else if (req0) begin
            gnt = 1'b0;
        end else if (req1) begin
            gnt = 1'b1;
        end

        g_sel   = gnt ? m1HSEL : m0HSEL;
        g_trans = g_sel ? (gnt ? m1HTRANS : m0HTRANS) : HTRANS_IDLE;

        owner_d  = owner_q;
        downer_d = downer_q;
        dvalid_d = dvalid_q;
        if (dHREADYOUT) begin
            owner_d  = gnt;
            downer_d = gnt;
            dvalid_d = g_sel & g_trans[1];
        end
    end

    // Downstream muxing and per-requester responses.
    always_comb begin
        dHSEL   = g_sel;
        dHTRANS = g_trans;
        dHADDR  = gnt ? m1HADDR  : m0HADDR;
        dHWRITE = gnt ? m1HWRITE : m0HWRITE;
        dHSIZE  = gnt ? m1HSIZE  : m0HSIZE;
        dHBURST = gnt ? m1HBURST : m0HBURST;
        dHPROT  = gnt ? m1HPROT  : m0HPROT;
        dHWDATA = downer_q ? m1HWDATA : m0HWDATA;
        dHREADY = dHREADYOUT;

        m0HRDATA = dHRDATA;
        m1HRDATA = dHRDATA;

        if (dvalid_q && !downer_q) begin
            m0HREADYOUT = dHREADYOUT;
        end else if (req0) begin
            m0HREADYOUT = !gnt ? dHREADYOUT : 1'b0;
        end else begin
            m0HREADYOUT = 1'b1;
        end

        if (dvalid_q && downer_q) begin
            m1HREADYOUT = dHREADYOUT;
        end else if (req1) begin
            m1HREADYOUT = gnt ? dHREADYOUT : 1'b0;
        end else begin
            m1HREADYOUT = 1'b1;
        end

        m0HRESP = (dvalid_q && !downer_q) ? dHRESP : 1'b0;
        m1HRESP = (dvalid_q &&  downer_q) ? dHRESP : 1'b0;
        owner_o = owner_q;
    end

endmodule

// File: tb/tb_ahb3lite_dma_master_arb.sv
// Directed bench for ahb3lite_dma_master_arb: a round-robin instance plus a
// fixed-priority instance sharing the same requester and slave stimulus.
module tb_ahb3lite_dma_master_arb;

    logic        clk_i = 1'b0;
    logic        rst_n_i;

    logic        m0HSEL, m0HWRITE, m0HREADY;
    logic [31:0] m0HADDR, m0HWDATA;
    logic [2:0]  m0HSIZE, m0HBURST;
    logic [3:0]  m0HPROT;
    logic [1:0]  m0HTRANS;
    logic        m1HSEL, m1HWRITE, m1HREADY;
    logic [31:0] m1HADDR, m1HWDATA;
    logic [2:0]  m1HSIZE, m1HBURST;
    logic [3:0]  m1HPROT;
    logic [1:0]  m1HTRANS;
    logic [31:0] dHRDATA;
    logic        dHREADYOUT, dHRESP;

    logic [31:0] m0HRDATA, m1HRDATA, dHADDR, dHWDATA;
    logic        m0HREADYOUT, m0HRESP, m1HREADYOUT, m1HRESP;
    logic        dHSEL, dHWRITE, dHREADY, owner_o;
    logic [2:0]  dHSIZE, dHBURST;
    logic [3:0]  dHPROT;
    logic [1:0]  dHTRANS;

    logic [31:0] fx_m0HRDATA, fx_m1HRDATA, fx_dHADDR, fx_dHWDATA;
    logic        fx_m0HREADYOUT, fx_m0HRESP, fx_m1HREADYOUT, fx_m1HRESP;
    logic        fx_dHSEL, fx_dHWRITE, fx_dHREADY, fx_owner_o;
    logic [2:0]  fx_dHSIZE, fx_dHBURST;
    logic [3:0]  fx_dHPROT;
    logic [1:0]  fx_dHTRANS;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    always #5 clk_i = ~clk_i;

    ahb3lite_dma_master_arb #(.PRI_FIXED(1'b0), .DEFAULT_OWNER(1'b0)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0HSEL(m0HSEL), .m0HWRITE(m0HWRITE), .m0HADDR(m0HADDR), .m0HWDATA(m0HWDATA),
        .m0HSIZE(m0HSIZE), .m0HBURST(m0HBURST), .m0HPROT(m0HPROT), .m0HTRANS(m0HTRANS),
        .m0HREADY(m0HREADY), .m0HRDATA(m0HRDATA), .m0HREADYOUT(m0HREADYOUT), .m0HRESP(m0HRESP),
        .m1HSEL(m1HSEL), .m1HWRITE(m1HWRITE), .m1HADDR(m1HADDR), .m1HWDATA(m1HWDATA),
        .m1HSIZE(m1HSIZE), .m1HBURST(m1HBURST), .m1HPROT(m1HPROT), .m1HTRANS(m1HTRANS),
        .m1HREADY(m1HREADY), .m1HRDATA(m1HRDATA), .m1HREADYOUT(m1HREADYOUT), .m1HRESP(m1HRESP),
        .dHSEL(dHSEL), .dHWRITE(dHWRITE), .dHADDR(dHADDR), .dHWDATA(dHWDATA),
        .dHSIZE(dHSIZE), .dHBURST(dHBURST), .dHPROT(dHPROT), .dHTRANS(dHTRANS),
        .dHREADY(dHREADY), .dHRDATA(dHRDATA), .dHREADYOUT(dHREADYOUT), .dHRESP(dHRESP),
        .owner_o(owner_o)
    );

    ahb3lite_dma_master_arb #(.PRI_FIXED(1'b1), .DEFAULT_OWNER(1'b0)) dut_fx (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .m0HSEL(m0HSEL), .m0HWRITE(m0HWRITE), .m0HADDR(m0HADDR), .m0HWDATA(m0HWDATA),
        .m0HSIZE(m0HSIZE), .m0HBURST(m0HBURST), .m0HPROT(m0HPROT), .m0HTRANS(m0HTRANS),
        .m0HREADY(m0HREADY), .m0HRDATA(fx_m0HRDATA), .m0HREADYOUT(fx_m0HREADYOUT), .m0HRESP(fx_m0HRESP),
        .m1HSEL(m1HSEL), .m1HWRITE(m1HWRITE), .m1HADDR(m1HADDR), .m1HWDATA(m1HWDATA),
        .m1HSIZE(m1HSIZE), .m1HBURST(m1HBURST), .m1HPROT(m1HPROT), .m1HTRANS(m1HTRANS),
        .m1HREADY(m1HREADY), .m1HRDATA(fx_m1HRDATA), .m1HREADYOUT(fx_m1HREADYOUT), .m1HRESP(fx_m1HRESP),
        .dHSEL(fx_dHSEL), .dHWRITE(fx_dHWRITE), .dHADDR(fx_dHADDR), .dHWDATA(fx_dHWDATA),
        .dHSIZE(fx_dHSIZE), .dHBURST(fx_dHBURST), .dHPROT(fx_dHPROT), .dHTRANS(fx_dHTRANS),
        .dHREADY(fx_dHREADY), .dHRDATA(dHRDATA), .dHREADYOUT(dHREADYOUT), .dHRESP(dHRESP),
        .owner_o(fx_owner_o)
    );

    task automatic idle_all();
        m0HSEL = 0; m0HTRANS = IDLE; m0HWRITE = 0; m0HADDR = 0; m0HWDATA = 0;
        m0HSIZE = 3'd2; m0HBURST = 0; m0HPROT = 4'h3; m0HREADY = 1;
        m1HSEL = 0; m1HTRANS = IDLE; m1HWRITE = 0; m1HADDR = 0; m1HWDATA = 0;
        m1HSIZE = 3'd2; m1HBURST = 0; m1HPROT = 4'h3; m1HREADY = 1;
        dHRDATA = 0; dHREADYOUT = 1; dHRESP = 0;
    endtask

    // Drive at the falling edge, sample 1 ns later, well away from the rising edge.
    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        idle_all();
        rst_n_i = 0;
        #12;
        checks++; if (dHTRANS !== IDLE) begin errors++; $display("FAIL reset_htrans got %0d exp 0", dHTRANS); end
        checks++; if (dHSEL !== 1'b0) begin errors++; $display("FAIL reset_hsel got %0b exp 0", dHSEL); end
        checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b11) begin errors++; $display("FAIL reset_hreadyout got %b exp 11", {m0HREADYOUT, m1HREADYOUT}); end
        checks++; if (owner_o !== 1'b0) begin errors++; $display("FAIL reset_owner got %0b exp 0", owner_o); end
        checks++; if ({m0HRESP, m1HRESP} !== 2'b00) begin errors++; $display("FAIL reset_hresp got %b exp 00", {m0HRESP, m1HRESP}); end
        step();
        rst_n_i = 1;
    endtask

    task automatic test_single_read();
        step();
        m0HSEL = 1; m0HTRANS = NONSEQ; m0HADDR = 32'h1000; m0HWRITE = 0;
        #1;
        checks++; if (dHADDR !== 32'h1000) begin errors++; $display("FAIL single_addr got %h exp 00001000", dHADDR); end
        checks++; if (dHTRANS !== NONSEQ) begin errors++; $display("FAIL single_trans got %0d exp 2", dHTRANS); end
        checks++; if (m0HREADYOUT !== 1'b1) begin errors++; $display("FAIL single_addr_ready got %0b exp 1", m0HREADYOUT); end
        step();
        m0HSEL = 0; m0HTRANS = IDLE; dHRDATA = 32'hCAFE0001;
        #1;
        checks++; if (m0HREADYOUT !== 1'b1) begin errors++; $display("FAIL single_data_ready got %0b exp 1", m0HREADYOUT); end
        checks++; if (m0HRDATA !== 32'hCAFE0001) begin errors++; $display("FAIL single_rdata got %h exp cafe0001", m0HRDATA); end
        checks++; if (dHTRANS !== IDLE) begin errors++; $display("FAIL single_idle got %0d exp 0", dHTRANS); end
        step();
        dHRDATA = 0;
    endtask

    task automatic test_tie_break();
        m0HSEL = 1; m0HTRANS = NONSEQ; m0HADDR = 32'h10;
        m1HSEL = 1; m1HTRANS = NONSEQ; m1HADDR = 32'h20;
        #1;
        checks++; if (dHADDR !== 32'h20) begin errors++; $display("FAIL rr_first_addr got %h exp 00000020", dHADDR); end
        checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b01) begin errors++; $display("FAIL rr_first_ready got %b exp 01", {m0HREADYOUT, m1HREADYOUT}); end
        checks++; if (fx_dHADDR !== 32'h10) begin errors++; $display("FAIL fixed_first_addr got %h exp 00000010", fx_dHADDR); end
        checks++; if ({fx_m0HREADYOUT, fx_m1HREADYOUT} !== 2'b10) begin errors++; $display("FAIL fixed_first_ready got %b exp 10", {fx_m0HREADYOUT, fx_m1HREADYOUT}); end
        step();
        m1HSEL = 0; m1HTRANS = IDLE;
        #1;
        checks++; if (owner_o !== 1'b1) begin errors++; $display("FAIL rr_owner got %0b exp 1", owner_o); end
        checks++; if (dHADDR !== 32'h10) begin errors++; $display("FAIL rr_second_addr got %h exp 00000010", dHADDR); end
        checks++; if (m0HREADYOUT !== 1'b1) begin errors++; $display("FAIL rr_second_ready got %0b exp 1", m0HREADYOUT); end
        step();
        m0HSEL = 0; m0HTRANS = IDLE;
        step();
    endtask

    task automatic test_burst_lock();
        logic [31:0] addrs [4];
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10C;
        for (int b = 0; b < 4; b++) begin
            m0HSEL = 1; m0HWRITE = 1; m0HBURST = 3'd3;
            m0HTRANS = (b == 0) ? NONSEQ : SEQ;
            m0HADDR = addrs[b];
            m0HWDATA = 32'hD000_0000 + b - 1;
            if (b == 1) begin
                m1HSEL = 1; m1HTRANS = NONSEQ; m1HADDR = 32'h200; m1HWDATA = 32'hBAD0BAD0;
            end
            #1;
            checks++; if (dHADDR !== addrs[b]) begin errors++; $display("FAIL burst_addr%0d got %h exp %h", b, dHADDR, addrs[b]); end
            if (b > 0) begin
                checks++; if (m1HREADYOUT !== 1'b0) begin errors++; $display("FAIL burst_m1_stall%0d got %0b exp 0", b, m1HREADYOUT); end
                checks++; if (dHWDATA !== 32'hD000_0000 + b - 1) begin errors++; $display("FAIL burst_wdata%0d got %h", b, dHWDATA); end
            end
            step();
        end
        m0HSEL = 0; m0HTRANS = IDLE; m0HWRITE = 0; m0HWDATA = 32'hD000_0003;
        #1;
        checks++; if (dHADDR !== 32'h200) begin errors++; $display("FAIL burst_handover_addr got %h exp 00000200", dHADDR); end
        checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b11) begin errors++; $display("FAIL burst_handover_ready got %b exp 11", {m0HREADYOUT, m1HREADYOUT}); end
        checks++; if (dHWDATA !== 32'hD000_0003) begin errors++; $display("FAIL burst_last_wdata got %h exp d0000003", dHWDATA); end
        step();
    endtask

    task automatic test_wait_states();
        m1HSEL = 0; m1HTRANS = IDLE;
        m0HSEL = 1; m0HTRANS = NONSEQ; m0HADDR = 32'h300; m0HBURST = 0;
        dHREADYOUT = 0;
        for (int w = 0; w < 2; w++) begin
            #1;
            checks++; if (owner_o !== 1'b1) begin errors++; $display("FAIL wait_owner%0d got %0b exp 1", w, owner_o); end
            checks++; if (dHADDR !== 32'h200) begin errors++; $display("FAIL wait_addr%0d got %h exp 00000200", w, dHADDR); end
            checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b00) begin errors++; $display("FAIL wait_ready%0d got %b exp 00", w, {m0HREADYOUT, m1HREADYOUT}); end
            step();
        end
        dHREADYOUT = 1;
        #1;
        checks++; if (dHADDR !== 32'h300) begin errors++; $display("FAIL wait_release_addr got %h exp 00000300", dHADDR); end
        checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b11) begin errors++; $display("FAIL wait_release_ready got %b exp 11", {m0HREADYOUT, m1HREADYOUT}); end
        step();
        m0HSEL = 0; m0HTRANS = IDLE;
        step();
    endtask

    task automatic test_error_and_reset();
        m1HSEL = 1; m1HTRANS = NONSEQ; m1HADDR = 32'h400;
        step();
        m1HADDR = 32'h404;
        m0HSEL = 1; m0HTRANS = NONSEQ; m0HADDR = 32'h500;
        dHREADYOUT = 0; dHRESP = 1;
        #1;
        checks++; if ({m1HRESP, m1HREADYOUT} !== 2'b10) begin errors++; $display("FAIL err1_m1 got %b exp 10", {m1HRESP, m1HREADYOUT}); end
        checks++; if ({m0HRESP, m0HREADYOUT} !== 2'b00) begin errors++; $display("FAIL err1_m0 got %b exp 00", {m0HRESP, m0HREADYOUT}); end
        step();
        m1HSEL = 0; m1HTRANS = IDLE; dHREADYOUT = 1;
        #1;
        checks++; if ({m1HRESP, m1HREADYOUT} !== 2'b11) begin errors++; $display("FAIL err2_m1 got %b exp 11", {m1HRESP, m1HREADYOUT}); end
        checks++; if (m0HRESP !== 1'b0) begin errors++; $display("FAIL err2_m0_resp got %0b exp 0", m0HRESP); end
        checks++; if (dHADDR !== 32'h500) begin errors++; $display("FAIL err2_handover got %h exp 00000500", dHADDR); end
        step();
        m0HSEL = 0; m0HTRANS = IDLE; dHRESP = 0;
        m1HSEL = 1; m1HTRANS = NONSEQ; m1HADDR = 32'h600; m1HBURST = 3'd1;
        step();
        m1HTRANS = SEQ; m1HADDR = 32'h604;
        #1;
        checks++; if (owner_o !== 1'b1) begin errors++; $display("FAIL preburst_owner got %0b exp 1", owner_o); end
        #1;
        rst_n_i = 0;
        m1HSEL = 0; m1HTRANS = IDLE;
        dHREADYOUT = 0; dHRESP = 1;
        #1;
        checks++; if (owner_o !== 1'b0) begin errors++; $display("FAIL async_owner got %0b exp 0", owner_o); end
        checks++; if ({m0HREADYOUT, m1HREADYOUT} !== 2'b11) begin errors++; $display("FAIL async_ready got %b exp 11", {m0HREADYOUT, m1HREADYOUT}); end
        checks++; if ({m0HRESP, m1HRESP} !== 2'b00) begin errors++; $display("FAIL async_resp got %b exp 00", {m0HRESP, m1HRESP}); end
        checks++; if ({dHSEL, dHTRANS} !== 3'b000) begin errors++; $display("FAIL async_dsel got %b exp 000", {dHSEL, dHTRANS}); end
        step();
        dHREADYOUT = 1; dHRESP = 0;
        rst_n_i = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_break();
        test_burst_lock();
        test_wait_states();
        test_error_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb3lite_dma_master_arb.md
# ahb3lite_dma_master_arb

Two-to-one AHB3-Lite master arbiter that shares one downstream AHB3-Lite master port between the DMA's two AHB master ports (wishbone interface 0 and 1, after their wb_to_ahb3lite bridges). It tracks address and data phases separately and stalls the losing requester through its HREADYOUT. It never breaks a burst or an outstanding data phase, and forwards responses to the data-phase owner only.

## Interface
Parameters:
- PRI_FIXED, 0: tie-break policy. 0 = round-robin; 1 = fixed, m0 wins.
- DEFAULT_OWNER, 0: address-phase owner after reset.

Ports. `m<n>` means one port for each of m0 and m1.
- clk_i  in  1  clock; all state on the rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- m<n>HSEL, m<n>HWRITE  in  1  requester select and direction
- m<n>HADDR, m<n>HWDATA  in  32  requester address and write data
- m<n>HSIZE, m<n>HBURST  in  3  requester size and burst
- m<n>HPROT  in  4  requester protection
- m<n>HTRANS  in  2  requester transfer type
- m<n>HREADY  in  1  ignored; the requester sees only HREADYOUT
- m<n>HRDATA  out  32  = dHRDATA, broadcast to both requesters
- m<n>HREADYOUT  out  1  transfer-done/stall indication to the requester
- m<n>HRESP  out  1  response, forwarded to the data-phase owner only
- dHSEL, dHWRITE  out  1  downstream select and direction
- dHADDR, dHWDATA  out  32  downstream address and write data
- dHSIZE, dHBURST  out  3  downstream size and burst
- dHPROT  out  4  downstream protection
- dHTRANS  out  2  downstream transfer type
- dHREADY  out  1  = dHREADYOUT
- dHRDATA  in  32  downstream read data
- dHREADYOUT, dHRESP  in  1  downstream ready and response
- owner_o  out  1  registered address-phase owner

## Operation
- req_n = m<n>HSEL & m<n>HTRANS[1], i.e. NONSEQ or SEQ.
- State registers:
  - owner: address-phase owner; reset to DEFAULT_OWNER.
  - dvalid: a downstream data phase is in progress; reset 0.
  - downer: data-phase owner; reset 0.
- Combinational grant gnt. Apply the first rule that matches:
  - dHREADYOUT=0 -> gnt=owner.
  - Lock -> gnt=owner. Lock holds when the owner has HSEL=1 with HTRANS SEQ or BUSY, or when the owner requests while dvalid=1 and downer=owner.
  - Both requesting -> gnt=0 if PRI_FIXED=1, else gnt=!owner.
  - Exactly one requesting -> that requester.
  - Otherwise -> gnt=owner.
- Downstream address and control (dHSEL, dHADDR, dHWRITE, dHSIZE, dHBURST, dHPROT) come from master gnt. dHTRANS = m<gnt>HSEL ? m<gnt>HTRANS : IDLE.
- dHWDATA comes from master downer.
- When dHREADYOUT=1:
  - owner <= gnt
  - downer <= gnt
  - dvalid <= dHSEL & dHTRANS[1]
- m<n>HREADYOUT:
  - dvalid & downer=n -> dHREADYOUT.
  - else if req_n -> (gnt=n ? dHREADYOUT : 0).
  - else -> 1.
- m<n>HRESP = (dvalid & downer=n) ? dHRESP : 0.
- A requester that is not granted is held in its address phase. It never holds an uncompleted data phase while stalled, so no response buffering is needed.
- Handover points:
  - the owner goes IDLE, or
  - the owner has no outstanding data phase and the other master wins the tie-break.
- BUSY inside a burst keeps the lock.

## Timing
- Address path is combinational, zero added latency. A granted NONSEQ appears on dHADDR/dHTRANS in the same cycle.
- The grant is frozen while dHREADYOUT=0 (wait states and ERROR cycle 1).
- ERROR: both response cycles are forwarded to downer. If downer drops to IDLE in cycle 2, handover is allowed in that cycle.
- Reset (asynchronous, any time, including mid-burst):
  - owner=DEFAULT_OWNER, dvalid=0, owner_o=DEFAULT_OWNER.
  - With both HSEL=0: m<n>HREADYOUT=1, m<n>HRESP=0, dHSEL=0, dHTRANS=IDLE.
  - In-flight transfers are discarded; there is no recovery.
- After release, the first accepted address can be presented in the first clock.

## Test plan
- Reset, both masters idle -> dHTRANS=IDLE, dHSEL=0, both HREADYOUT=1, owner_o=0.
- m0 single NONSEQ read at 0x1000, slave returns 0xCAFE0001 with zero waits -> dHADDR=0x1000 in the same cycle; next cycle m0HREADYOUT=1 with m0HRDATA=0xCAFE0001.
- From idle, owner=0, PRI_FIXED=0, both issue NONSEQ (m0 to 0x10, m1 to 0x20) -> m1 is granted first (dHADDR=0x20) while m0HREADYOUT=0; m0 is accepted the next cycle. With PRI_FIXED=1, m0 goes first.
- m0 INCR4 write to 0x100; m1 requests at beat 2 -> dHADDR sequence 0x100, 0x104, 0x108, 0x10C; m1 stalled (HREADYOUT=0) until m0 goes IDLE, then m1's address issues.
- m1 data phase with dHREADYOUT low for 2 cycles while m0 requests -> owner_o, downer and dHADDR unchanged; m1HREADYOUT low for 2 cycles; m0 is granted only after m1 goes IDLE.
- dHRESP ERROR on m1's data phase -> m1HRESP=1 for 2 cycles (HREADYOUT 0 then 1) and m0HRESP=0. Then assert rst_n_i=0 mid-burst -> reset values are reached asynchronously.
